mp4_sram_1rw1r: RTL and testbench

//  Parametrised dual-port SRAM behavioural model: port 0 read/write with masked writes, port 1 read-only.

---
 rtl/mp4_sram_1rw1r.sv | 216 +++++++++++++++++++++
 tb/tb_mp4_sram_1rw1r.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mp4_sram_1rw1r.sv
// ---------------------------------------------------------------------------
// mp4_sram_1rw1r
//   Dual-port SRAM behavioural model for cache data/tag arrays.
//   Port 0 is read/write with per-lane write masks; port 1 is read-only.
//   One pipeline stage can read on port 1 while the fill/writeback path
//   writes on port 0.
//
//   Features:
//     - selectable read latency (1 or 2 clk0 edges), fully pipelined
//     - one-cycle rvalid strobes per accepted read; dout holds otherwise
//     - defined same-address collision policy (WRITE_FIRST)
//     - optional post-reset zero-initialisation sweep (INIT_ZERO)
//
// Ports:
//   clk0     in   clock, all state changes on posedge
//   rstb0    in   asynchronous active-low reset
//   csb0     in   port 0 chip select (active low)
//   web0     in   port 0 write enable (active low)
//   wmask0   in   port 0 write lane enables, one bit per WMASK_GRAN bits
//   addr0    in   port 0 address
//   din0     in   port 0 write data
//   dout0    out  port 0 read data (holds between reads)
//   rvalid0  out  port 0 read result strobe
//   csb1     in   port 1 chip select (active low, read only)
//   addr1    in   port 1 address
//   dout1    out  port 1 read data (holds between reads)
//   rvalid1  out  port 1 read result strobe
//   ready    out  requests accepted (zero sweep complete)
// ---------------------------------------------------------------------------
module mp4_sram_1rw1r #(
    parameter int DATA_WIDTH  = 256,
    parameter int ADDR_WIDTH  = 4,
    parameter int WMASK_GRAN  = 8,
    parameter int READ_LAT    = 1,
    parameter int WRITE_FIRST = 1,
    parameter int INIT_ZERO   = 1,
    localparam int NUM_WMASKS = DATA_WIDTH / WMASK_GRAN,
    localparam int RAM_DEPTH  = 1 << ADDR_WIDTH
) (
    input  logic                  clk0,
    input  logic                  rstb0,
    input  logic                  csb0,
    input  logic                  web0,
    input  logic [NUM_WMASKS-1:0] wmask0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] din0,
    output logic [DATA_WIDTH-1:0] dout0,
    output logic                  rvalid0,
    input  logic                  csb1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    output logic [DATA_WIDTH-1:0] dout1,
    output logic                  rvalid1,
    output logic                  ready
);

    // -----------------------------------------------------------------------
    // Elaboration-time parameter checks
    // -----------------------------------------------------------------------
    if (DATA_WIDTH % WMASK_GRAN != 0) begin : g_bad_gran
        $error("mp4_sram_1rw1r: DATA_WIDTH must be a multiple of WMASK_GRAN");
    end
    if (READ_LAT != 1 && READ_LAT != 2) begin : g_bad_lat
        $error("mp4_sram_1rw1r: READ_LAT must be 1 or 2");
    end

    // -----------------------------------------------------------------------
    // Storage. Never reset: only the init sweep or port 0 writes change it.
    // -----------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem_q [RAM_DEPTH];

    // -----------------------------------------------------------------------
    // Init / ready FSM
    // -----------------------------------------------------------------------
    typedef enum logic {
        ST_INIT,
        ST_READY
    } state_e;

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] cnt_q;
    logic                  ready_q;

    always_ff @(posedge clk0 or negedge rstb0) begin
        if (!rstb0) begin
            state_q <= (INIT_ZERO != 0) ? ST_INIT : ST_READY;
            cnt_q   <= '0;
            ready_q <= (INIT_ZERO == 0);
        end else begin
            case (state_q)
                ST_INIT: begin
                    cnt_q <= cnt_q + 1'b1;
                    // Leave INIT on the edge that clears the last word.
                    if (cnt_q == ADDR_WIDTH'(RAM_DEPTH - 1)) begin
                        state_q <= ST_READY;
                        ready_q <= 1'b1;
                    end
                end
                default: ;  // READY is terminal until the next reset
            endcase
        end
    end

    assign ready = ready_q;

    // -----------------------------------------------------------------------
    // Request decode. Everything is gated by ready, so the sweep ignores
    // csb/web entirely. An all-zero mask is treated as no write at all.
    // -----------------------------------------------------------------------
    logic init_wr;
    logic wr0_en;
    logic rd0_en;
    logic rd1_en;
    logic addr_eq;

    // The sweep must not write while reset is held, otherwise reset itself
    // would keep clearing word 0.
    assign init_wr = (state_q == ST_INIT) && rstb0;
    assign wr0_en  = ready_q && !csb0 && !web0 && (|wmask0);
    assign rd0_en  = ready_q && !csb0 &&  web0;
    assign rd1_en  = ready_q && !csb1;
    assign addr_eq = (addr0 == addr1);

    // -----------------------------------------------------------------------
    // Read data for the capture stage. Port 0 reads the array as it was
    // before the edge. Port 1 bypasses din0 per lane on a same-address
    // write when write-first is selected.
    // -----------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] rd0_data_d;
    logic [DATA_WIDTH-1:0] rd1_data_d;
    logic [DATA_WIDTH-1:0] rd1_old;

    assign rd0_data_d = mem_q[addr0];
    assign rd1_old    = mem_q[addr1];

    for (genvar i = 0; i < NUM_WMASKS; i++) begin : g_lane
        logic byp;
        assign byp = (WRITE_FIRST != 0) && wr0_en && addr_eq && wmask0[i];
        assign rd1_data_d[i*WMASK_GRAN +: WMASK_GRAN] =
            byp ? din0[i*WMASK_GRAN +: WMASK_GRAN]
                : rd1_old[i*WMASK_GRAN +: WMASK_GRAN];
    end

    // -----------------------------------------------------------------------
    // Array write: init sweep or masked port 0 write.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk0) begin
        if (init_wr) begin
            mem_q[cnt_q] <= '0;
        end else if (wr0_en) begin
            for (int i = 0; i < NUM_WMASKS; i++) begin
                if (wmask0[i]) begin
                    mem_q[addr0][i*WMASK_GRAN +: WMASK_GRAN] <=
                        din0[i*WMASK_GRAN +: WMASK_GRAN];
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Read pipeline, capture stage (edge N). Data registers only load on a
    // valid read so the outputs hold their last result between reads.
    // -----------------------------------------------------------------------
    logic                  s0_vld0_q;
    logic                  s0_vld1_q;
    logic [DATA_WIDTH-1:0] s0_dat0_q;
    logic [DATA_WIDTH-1:0] s0_dat1_q;

    always_ff @(posedge clk0 or negedge rstb0) begin
        if (!rstb0) begin
            s0_vld0_q <= 1'b0;
            s0_vld1_q <= 1'b0;
            s0_dat0_q <= '0;
            s0_dat1_q <= '0;
        end else begin
            s0_vld0_q <= rd0_en;
            s0_vld1_q <= rd1_en;
            if (rd0_en) s0_dat0_q <= rd0_data_d;
            if (rd1_en) s0_dat1_q <= rd1_data_d;
        end
    end

    // -----------------------------------------------------------------------
    // Optional second stage (edge N+1) for READ_LAT=2.
    // -----------------------------------------------------------------------
    if (READ_LAT == 2) begin : g_lat2
        logic                  s1_vld0_q;
        logic                  s1_vld1_q;
        logic [DATA_WIDTH-1:0] s1_dat0_q;
        logic [DATA_WIDTH-1:0] s1_dat1_q;

        always_ff @(posedge clk0 or negedge rstb0) begin
            if (!rstb0) begin
                s1_vld0_q <= 1'b0;
                s1_vld1_q <= 1'b0;
                s1_dat0_q <= '0;
                s1_dat1_q <= '0;
            end else begin
                s1_vld0_q <= s0_vld0_q;
                s1_vld1_q <= s0_vld1_q;
                if (s0_vld0_q) s1_dat0_q <= s0_dat0_q;
                if (s0_vld1_q) s1_dat1_q <= s0_dat1_q;
            end
        end

        assign dout0   = s1_dat0_q;
        assign rvalid0 = s1_vld0_q;
        assign dout1   = s1_dat1_q;
        assign rvalid1 = s1_vld1_q;
    end else begin : g_lat1
        assign dout0   = s0_dat0_q;
        assign rvalid0 = s0_vld0_q;
        assign dout1   = s0_dat1_q;
        assign rvalid1 = s0_vld1_q;
    end

endmodule

// File: tb/tb_mp4_sram_1rw1r.sv
module tb_mp4_sram_1rw1r;

    localparam int AW  = 4;
    localparam int DWA = 256;
    localparam int GA  = 8;
    localparam int MA  = DWA / GA;
    localparam int DWB = 64;
    localparam int GB  = 16;
    localparam int MB  = DWB / GB;

    logic clk0  = 1'b0;
    logic rstb0 = 1'b1;

    // DUT a: 256b, 8b lanes, READ_LAT=1, WRITE_FIRST=1
    logic           a_csb0, a_web0, a_csb1;
    logic [MA-1:0]  a_wmask0;
    logic [AW-1:0]  a_addr0, a_addr1;
    logic [DWA-1:0] a_din0, a_dout0, a_dout1;
    logic           a_rvalid0, a_rvalid1, a_ready;

    // DUT b: 64b, 16b lanes, READ_LAT=2, WRITE_FIRST=0
    logic           b_csb0, b_web0, b_csb1;
    logic [MB-1:0]  b_wmask0;
    logic [AW-1:0]  b_addr0, b_addr1;
    logic [DWB-1:0] b_din0, b_dout0, b_dout1;
    logic           b_rvalid0, b_rvalid1, b_ready;

    mp4_sram_1rw1r #(
        .DATA_WIDTH(DWA), .ADDR_WIDTH(AW), .WMASK_GRAN(GA),
        .READ_LAT(1), .WRITE_FIRST(1), .INIT_ZERO(1)
    ) u_a (
        .clk0(clk0), .rstb0(rstb0), .csb0(a_csb0), .web0(a_web0),
        .wmask0(a_wmask0), .addr0(a_addr0), .din0(a_din0), .dout0(a_dout0),
        .rvalid0(a_rvalid0), .csb1(a_csb1), .addr1(a_addr1), .dout1(a_dout1),
        .rvalid1(a_rvalid1), .ready(a_ready)
    );

    mp4_sram_1rw1r #(
        .DATA_WIDTH(DWB), .ADDR_WIDTH(AW), .WMASK_GRAN(GB),
        .READ_LAT(2), .WRITE_FIRST(0), .INIT_ZERO(1)
    ) u_b (
        .clk0(clk0), .rstb0(rstb0), .csb0(b_csb0), .web0(b_web0),
        .wmask0(b_wmask0), .addr0(b_addr0), .din0(b_din0), .dout0(b_dout0),
        .rvalid0(b_rvalid0), .csb1(b_csb1), .addr1(b_addr1), .dout1(b_dout1),
        .rvalid1(b_rvalid1), .ready(b_ready)
    );

    always #5 clk0 = ~clk0;

    int cyc = 0;
    always @(posedge clk0) cyc <= cyc + 1;

    // Scoreboard: 0 = a.port0, 1 = a.port1, 2 = b.port0, 3 = b.port1
    typedef struct {
        logic [255:0] data;
        int           cyc;
    } exp_t;

    exp_t sbq[4][$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp_v);
        end
    endtask

    task automatic sb_mon(input int p, input logic vld, input logic [255:0] dat);
        exp_t e;
        if (vld) begin
            if (sbq[p].size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL sb%0d unexpected rvalid at cyc %0d: got %h want none", p, cyc, dat);
            end else begin
                e = sbq[p].pop_front();
                check($sformatf("sb%0d data", p), dat, e.data);
                check($sformatf("sb%0d cycle", p), 256'(cyc), 256'(e.cyc));
            end
        end else if (sbq[p].size() != 0 && sbq[p][0].cyc <= cyc) begin
            e = sbq[p].pop_front();
            n_cmp++;
            n_err++;
            $display("FAIL sb%0d missing rvalid: got none at cyc %0d want data %h", p, cyc, e.data);
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk0) begin
        if (rstb0) begin
            sb_mon(0, a_rvalid0, 256'(a_dout0));
            sb_mon(1, a_rvalid1, 256'(a_dout1));
            sb_mon(2, b_rvalid0, 256'(b_dout0));
            sb_mon(3, b_rvalid1, 256'(b_dout1));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge clk0);
    endtask

    task automatic idle();
        a_csb0 = 1'b1; a_web0 = 1'b1; a_wmask0 = '0; a_addr0 = '0; a_din0 = '0;
        a_csb1 = 1'b1; a_addr1 = '0;
        b_csb0 = 1'b1; b_web0 = 1'b1; b_wmask0 = '0; b_addr0 = '0; b_din0 = '0;
        b_csb1 = 1'b1; b_addr1 = '0;
    endtask

    task automatic push(input int p, input logic [255:0] d, input int lat);
        exp_t e;
        e.data = d;
        e.cyc  = cyc + lat;
        sbq[p].push_back(e);
    endtask

    task automatic a_wr(input logic [AW-1:0] ad, input logic [DWA-1:0] d, input logic [MA-1:0] m);
        a_csb0 = 1'b0; a_web0 = 1'b0; a_addr0 = ad; a_din0 = d; a_wmask0 = m;
    endtask
    task automatic a_rd0(input logic [AW-1:0] ad, input logic [DWA-1:0] ev);
        a_csb0 = 1'b0; a_web0 = 1'b1; a_addr0 = ad; push(0, 256'(ev), 1);
    endtask
    task automatic a_rd1(input logic [AW-1:0] ad, input logic [DWA-1:0] ev);
        a_csb1 = 1'b0; a_addr1 = ad; push(1, 256'(ev), 1);
    endtask
    task automatic b_wr(input logic [AW-1:0] ad, input logic [DWB-1:0] d, input logic [MB-1:0] m);
        b_csb0 = 1'b0; b_web0 = 1'b0; b_addr0 = ad; b_din0 = d; b_wmask0 = m;
    endtask
    task automatic b_rd0(input logic [AW-1:0] ad, input logic [DWB-1:0] ev);
        b_csb0 = 1'b0; b_web0 = 1'b1; b_addr0 = ad; push(2, 256'(ev), 2);
    endtask
    task automatic b_rd1(input logic [AW-1:0] ad, input logic [DWB-1:0] ev);
        b_csb1 = 1'b0; b_addr1 = ad; push(3, 256'(ev), 2);
    endtask

    // Counts falling edges with ready low, starting at the release edge.
    task automatic wait_ready(output int na, output int nb);
        na = 0;
        nb = 0;
        for (int k = 0; k < 100; k++) begin
            if (!a_ready) na++;
            if (!b_ready) nb++;
            if (a_ready && b_ready) break;
            tick();
        end
    endtask

    task automatic drain(input string nm);
        repeat (5) tick();
        check(nm, 256'(sbq[0].size() + sbq[1].size() + sbq[2].size() + sbq[3].size()), 256'(0));
    endtask

    // Expected constants
    logic [DWA-1:0] A_LO64, A_3C, A_A5, A_MIX;
    logic [DWB-1:0] B_3C, B_A5;

    initial begin
        int na, nb;
        A_LO64 = {192'b0, {64{1'b1}}};
        A_3C   = {32{8'h3C}};
        A_A5   = {32{8'hA5}};
        A_MIX  = {{28{8'h3C}}, {4{8'hA5}}};
        B_3C   = {8{8'h3C}};
        B_A5   = {8{8'hA5}};

        idle();
        #2 rstb0 = 1'b0;
        repeat (2) tick();
        check("rst a.ready", 256'(a_ready), 256'(0));
        check("rst b.ready", 256'(b_ready), 256'(0));
        check("rst rvalids", 256'({a_rvalid0, a_rvalid1, b_rvalid0, b_rvalid1}), 256'(0));
        check("rst a.dout", 256'(a_dout0 | a_dout1), 256'(0));

        // Sweep length: ready low for exactly RAM_DEPTH cycles
        rstb0 = 1'b1;
        wait_ready(na, nb);
        check("sweep a low cycles", 256'(na), 256'(16));
        check("sweep b low cycles", 256'(nb), 256'(16));

        // All words zero after sweep, back-to-back port-1 reads
        for (int i = 0; i < 16; i++) begin
            tick(); idle();
            a_rd1(4'(i), '0);
            b_rd1(4'(i), '0);
        end

        // Masked write, zero-mask no-op, back-to-back writes on b
        tick(); idle(); a_wr(4'd3, '1, 32'h0000_00FF); b_wr(4'd0, 64'd10, 4'hF);
        tick(); idle(); a_rd0(4'd3, A_LO64);          b_wr(4'd1, 64'd11, 4'hF);
        tick(); idle(); a_wr(4'd3, '0, '0);           b_wr(4'd2, 64'd12, 4'hF);
        tick(); idle(); a_rd0(4'd3, A_LO64);          b_rd1(4'd0, 64'd10);
        tick(); idle(); a_wr(4'd5, A_3C, '1);         b_rd1(4'd1, 64'd11);
        // Collision, write-first on a
        tick(); idle(); a_wr(4'd5, A_A5, '1); a_rd1(4'd5, A_A5); b_rd1(4'd2, 64'd12);
        tick(); idle(); a_rd0(4'd5, A_A5); a_rd1(4'd5, A_A5);
                        b_wr(4'd4, 64'h1111_2222_3333_4444, 4'b1010);
        tick(); idle(); a_wr(4'd6, A_3C, '1); b_rd0(4'd4, 64'h1111_0000_3333_0000);
        // Partial-mask collision on a; prime old data on b
        tick(); idle(); a_wr(4'd6, A_A5, 32'h0000_000F); a_rd1(4'd6, A_MIX);
                        b_wr(4'd5, B_3C, 4'hF);
        // csb0 high write is ignored; read-first collision on b
        tick(); idle(); a_wr(4'd7, '1, '1); a_csb0 = 1'b1;
                        b_wr(4'd5, B_A5, 4'hF); b_rd1(4'd5, B_3C);
        tick(); idle(); a_rd0(4'd7, '0); a_rd1(4'd6, A_MIX);
                        b_rd0(4'd5, B_A5); b_rd1(4'd5, B_A5);
        tick(); idle(); a_rd0(4'd5, A_A5); a_rd1(4'd6, A_MIX);
                        b_rd0(4'd4, 64'h1111_0000_3333_0000); b_rd1(4'd1, 64'd11);
        tick(); idle();
        drain("drain phase 1");

        // Reset clears outputs while memory keeps data until the sweep
        tick(); rstb0 = 1'b0;
        tick();
        check("reset2 a.dout", 256'(a_dout0 | a_dout1), 256'(0));
        check("reset2 b.dout", 256'(b_dout0 | b_dout1), 256'(0));
        check("reset2 rvalids", 256'({a_rvalid0, a_rvalid1, b_rvalid0, b_rvalid1}), 256'(0));

        // Abort the sweep at count 7 and restart it
        rstb0 = 1'b1;
        repeat (7) tick();
        rstb0 = 1'b0;
        tick();
        check("midsweep ready", 256'({a_ready, b_ready}), 256'(0));
        check("midsweep rvalids", 256'({a_rvalid0, a_rvalid1, b_rvalid0, b_rvalid1}), 256'(0));
        rstb0 = 1'b1;
        wait_ready(na, nb);
        check("resweep a low cycles", 256'(na), 256'(16));
        check("resweep b low cycles", 256'(nb), 256'(16));

        for (int i = 0; i < 16; i++) begin
            tick(); idle();
            a_rd0(4'(i), '0);
            a_rd1(4'(15 - i), '0);
            b_rd0(4'(i), '0);
            b_rd1(4'(15 - i), '0);
        end
        tick(); idle();
        drain("drain phase 2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
